cb_safe_mode_sequencer: RTL
===========================

# cb_safe_mode_sequencer

Sequencer for the safe CPU wrapper. It accepts a mode-change request, halts the cores, and applies the new safe mode, configuration, master core and boot address while the cores are quiescent. It then releases the cores, drives start, and waits for the end-of-software event. A watchdog bounds the halt and run phases, and every completion or failure is reported with a status code.

## Interface
Parameters:
- NCores, 3, number of cores in the wrapper
- TimeoutW, 24, width of watchdog limit and counter
- BootAddrRst, 32'h0, reset value of boot_addr_o

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  mode-change request
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_safe_mode_i  in  1  requested safe mode
- req_config_i  in  2  requested safe configuration
- req_master_i  in  3  requested master core
- req_boot_addr_i  in  32  requested boot address
- timeout_i  in  TimeoutW  watchdog limit in cycles; 0 disables the watchdog
- abort_i  in  1  cancel the sequence in progress
- core_halt_req_o  out  NCores  halt request, one bit per core
- core_halted_i  in  NCores  per-core halted acknowledge
- end_sw_i  in  1  end-of-software level from the wrapper
- safe_mode_o  out  1  applied safe mode
- safe_configuration_o  out  2  applied configuration
- master_core_o  out  3  applied master core
- boot_addr_o  out  32  applied boot address
- start_o  out  1  start level to the wrapper
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle success pulse
- error_o  out  1  one-cycle failure pulse
- status_o  out  2  last result: 0 OK, 1 HALT_TO, 2 RUN_TO, 3 ABORT

## Operation
States: IDLE, HALT, CONFIG, RUN, DONE, ERROR.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch all req_* fields into shadow registers and go to HALT.
- HALT:
  - core_halt_req_o all ones.
  - When core_halted_i is all ones, go to CONFIG.
  - On watchdog expiry: status HALT_TO, go to ERROR; applied config is unchanged.
- CONFIG:
  - Lasts one cycle; core_halt_req_o stays all ones.
  - Shadow registers are copied to the applied outputs at the end of this cycle.
  - Next state is RUN.
- RUN:
  - core_halt_req_o=0, start_o=1.
  - A rising edge of end_sw_i (current 1, previous sample 0) sets status OK and goes to DONE.
  - On watchdog expiry: status RUN_TO, go to ERROR.
- DONE: done_o=1 for one cycle, then IDLE.
- ERROR: error_o=1 for one cycle, then IDLE.
- abort_i in HALT, CONFIG or RUN: status ABORT, go to ERROR.
  - If abort_i arrives in CONFIG, the applied-config update is suppressed.
- abort_i in IDLE, DONE or ERROR is ignored.
- Watchdog:
  - Counter clears on entry to HALT and to RUN, then increments once per cycle in that state.
  - Expires when the count equals timeout_i - 1, i.e. after timeout_i full cycles in the state.
  - The counter saturates. timeout_i=0 means it never expires.
  - timeout_i is sampled live each cycle.
- Priority within one cycle: abort_i > exit condition (all halted / end_sw_i edge) > watchdog expiry.
- end_sw_i already high on entry to RUN is not an edge; the block waits for a fresh 0→1 transition. The previous-sample flop runs in every state.
- req_valid_i outside IDLE is not accepted and has no effect.
- status_o holds its value until the next DONE or ERROR.

## Timing
- Reset values:
  - Outputs: state IDLE, req_ready_o=1, core_halt_req_o=0, start_o=0, busy_o=0, done_o=0, error_o=0, status_o=0.
  - Applied config: safe_mode_o=0, safe_configuration_o=0, master_core_o=0, boot_addr_o=BootAddrRst.
  - Watchdog counter 0; end_sw_i previous-sample flop 0.
- Reset asserted mid-sequence returns everything to these values immediately; no done_o or error_o pulse is generated.
- All outputs are decoded from registers; there are no input-to-output combinational paths.
- Minimum sequence, with the request accepted at edge k and cores already halted:
  - k+1: HALT.
  - k+2: CONFIG.
  - k+3: RUN; start_o=1 and the new config are visible together.
- end_sw_i edge sampled in cycle r: r+1 is DONE (start_o=0, done_o=1); r+2 is IDLE with req_ready_o=1.
- The earliest next request is accepted in the first IDLE cycle.

## Structure
- Package cb_safe_seq_pkg holds:
  - state enum;
  - status enum (OK, HALT_TO, RUN_TO, ABORT);
  - a packed cfg_t struct {safe_mode, config, master, boot_addr}.
- Sub-module cb_safe_seq_watchdog: clear, enable, limit in; expired out; saturating TimeoutW counter.

## Test plan
- Nominal sequence:
  - Stimulus: request {1, 2'b10, 3'b010, 32'h2000_0000}, timeout 100, cores halt 3 cycles after the request, end_sw_i rises 20 cycles into RUN.
  - Response: outputs update on the cycle start_o rises; done_o pulses once; status_o=0.
- Halt timeout:
  - Stimulus: timeout 8, one core never halts.
  - Response: error_o pulses 8 cycles after HALT entry; status_o=1; config unchanged; halt requests released.
- Run timeout and abort:
  - Stimulus: timeout 16 with no end_sw_i edge → status 2, start_o drops.
  - Stimulus: abort_i in RUN cycle 5 → status 3 at the next cycle.
- Simultaneous events:
  - Stimulus: end_sw_i edge in the same cycle as watchdog expiry.
  - Response: DONE.
  - Stimulus: abort_i in the same cycle as halted all ones.
  - Response: ERROR/ABORT, config unchanged.
- end_sw_i level-high on entry to RUN: no DONE until end_sw_i falls and rises again; timeout_i=0 waits indefinitely.
- Reset asserted in CONFIG and in RUN: all outputs return to their reset values at once; no done_o or error_o pulse.

Source files
------------

// File: rtl/cb_safe_seq_pkg.sv
// Shared types for the safe-mode sequencer.
//   state_e  : sequencer FSM states
//   status_e : result code reported on status_o
//   cfg_t    : one complete safe-mode configuration (shadow and applied copies)
package cb_safe_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HALT   = 3'd1,
        S_CONFIG = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_HALT_TO = 2'd1,
        STAT_RUN_TO  = 2'd2,
        STAT_ABORT   = 2'd3
    } status_e;

    // "config" is a reserved word, so the configuration field is safe_config.
    typedef struct packed {
        logic        safe_mode;
        logic [1:0]  safe_config;
        logic [2:0]  master;
        logic [31:0] boot_addr;
    } cfg_t;

endpackage

// File: rtl/cb_safe_seq_watchdog.sv
// Saturating phase watchdog.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : restart the count at zero (has priority over enable_i)
//   enable_i     : count one cycle
//   limit_i      : limit in cycles, 0 disables expiry (sampled live)
//   expired_o    : count has reached limit_i - 1
module cb_safe_seq_watchdog #(
    parameter int unsigned TimeoutW = 24
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic [TimeoutW-1:0] limit_i,
    output logic                expired_o
);

    localparam logic [TimeoutW-1:0] One = TimeoutW'(1);

    logic [TimeoutW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + One;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count is 0 in the first cycle of a phase, so matching limit-1
    // flags the last of limit_i full cycles.
    assign expired_o = (limit_i != '0) && (cnt_q == (limit_i - One));

endmodule

// File: rtl/cb_safe_mode_sequencer.sv
// Safe-mode change sequencer for the safe CPU wrapper.
// Accepts a request, halts all cores, applies the new configuration while
// they are quiescent, releases them with start_o and waits for end_sw_i.
//   req_*          : request handshake and requested configuration
//   timeout_i      : watchdog limit for HALT and RUN (0 = none)
//   abort_i        : cancel the sequence in progress
//   core_halt_req_o/core_halted_i : per-core halt handshake
//   end_sw_i       : end-of-software level (rising edge completes RUN)
//   safe_mode_o .. boot_addr_o    : applied configuration
//   start_o, busy_o, done_o, error_o, status_o : sequencing status
module cb_safe_mode_sequencer
    import cb_safe_seq_pkg::*;
#(
    parameter int unsigned NCores      = 3,
    parameter int unsigned TimeoutW    = 24,
    parameter logic [31:0] BootAddrRst = 32'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_safe_mode_i,
    input  logic [1:0]          req_config_i,
    input  logic [2:0]          req_master_i,
    input  logic [31:0]         req_boot_addr_i,
    input  logic [TimeoutW-1:0] timeout_i,
    input  logic                abort_i,
    output logic [NCores-1:0]   core_halt_req_o,
    input  logic [NCores-1:0]   core_halted_i,
    input  logic                end_sw_i,
    output logic                safe_mode_o,
    output logic [1:0]          safe_configuration_o,
    output logic [2:0]          master_core_o,
    output logic [31:0]         boot_addr_o,
    output logic                start_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [1:0]          status_o
);

    localparam cfg_t CfgRst = '{safe_mode: 1'b0, safe_config: 2'b00,
                                master: 3'b000, boot_addr: BootAddrRst};

    state_e  state_q, state_d;
    status_e status_q, status_d;
    cfg_t    shadow_q, applied_q;
    logic    end_sw_prev_q;
    logic    end_sw_rise;
    logic    all_halted;
    logic    wd_clear, wd_enable, wd_expired;
    logic    apply_cfg;
    logic    latch_req;

    assign end_sw_rise = end_sw_i && !end_sw_prev_q;
    assign all_halted  = &core_halted_i;

    // The watchdog restarts on every entry into a timed phase.
    assign wd_clear  = ((state_d == S_HALT) && (state_q != S_HALT)) ||
                       ((state_d == S_RUN)  && (state_q != S_RUN));
    assign wd_enable = (state_q == S_HALT) || (state_q == S_RUN);

    cb_safe_seq_watchdog #(
        .TimeoutW (TimeoutW)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .limit_i   (timeout_i),
        .expired_o (wd_expired)
    );

    // State register plus the registers it controls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            status_q      <= STAT_OK;
            shadow_q      <= CfgRst;
            applied_q     <= CfgRst;
            end_sw_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            end_sw_prev_q <= end_sw_i;
            if (latch_req) begin
                shadow_q <= '{safe_mode: req_safe_mode_i, safe_config: req_config_i,
                              master: req_master_i, boot_addr: req_boot_addr_i};
            end
            if (apply_cfg) begin
                applied_q <= shadow_q;
            end
        end
    end

    // Next state; abort beats the exit condition, which beats the watchdog.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        latch_req = 1'b0;
        apply_cfg = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    latch_req = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_HALT: begin
                if (abort_i) begin
                    status_d = STAT_ABORT;
                    state_d  = S_ERROR;
                end else if (all_halted) begin
                    state_d  = S_CONFIG;
                end else if (wd_expired) begin
                    status_d = STAT_HALT_TO;
                    state_d  = S_ERROR;
                end
            end
            S_CONFIG: begin
                if (abort_i) begin
                    status_d = STAT_ABORT;
                    state_d  = S_ERROR;
                end else begin
                    apply_cfg = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    status_d = STAT_ABORT;
                    state_d  = S_ERROR;
                end else if (end_sw_rise) begin
                    status_d = STAT_OK;
                    state_d  = S_DONE;
                end else if (wd_expired) begin
                    status_d = STAT_RUN_TO;
                    state_d  = S_ERROR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        req_ready_o     = (state_q == S_IDLE);
        busy_o          = (state_q != S_IDLE);
        core_halt_req_o = ((state_q == S_HALT) || (state_q == S_CONFIG)) ? '1 : '0;
        start_o         = (state_q == S_RUN);
        done_o          = (state_q == S_DONE);
        error_o         = (state_q == S_ERROR);
        status_o        = status_q;
        safe_mode_o          = applied_q.safe_mode;
        safe_configuration_o = applied_q.safe_config;
        master_core_o        = applied_q.master;
        boot_addr_o          = applied_q.boot_addr;
    end

endmodule
